rsa_modexp_engine: RTL and testbench
====================================

// Module: rsa_modexp_engine
// PURPOSE
//  Consumes the (n, e, d) key set produced by the key generator and performs RSA encrypt/decrypt:
//  result = msg^exp mod n, with exp = e (encrypt) or d (decrypt).
//  Right-to-left square-and-multiply with two parallel bit-serial interleaved modular multipliers.
//  Single start/done handshake; sits between key generation and the message stimulus/checker path.
// PARAMETERS
//  KEY_WIDTH  64  width of n, exp, msg, result (W below); must be >= 4
// PORTS
//  clk     in   1  rising-edge clock
//  rst     in   1  synchronous, active-high reset
//  start   in   1  request; sampled only in IDLE
//  msg     in   W  message/ciphertext; must satisfy msg < n
//  exp     in   W  exponent (e or d)
//  n       in   W  modulus; must satisfy n >= 2
//  busy    out  1  high from cycle after start accepted until done cycle inclusive
//  done    out  1  one-cycle pulse; result/err valid on that cycle and held until next accept
//  result  out  W  msg^exp mod n (0 on error)
//  err     out  1  operand error (msg >= n or n < 2)
// BEHAVIOUR
//  Reset: busy=0, done=0, err=0, result=0, FSM=IDLE; applies mid-operation, in-flight job discarded.
//  Accept: start=1 in IDLE latches msg/exp/n into internal regs; later input changes ignored.
//  start while not IDLE is ignored (no queueing).
//  FSM: IDLE -> CHECK -> {ERR | MUL} ; MUL -> UPD ; UPD -> {MUL | FIN} ; ERR/FIN -> IDLE.
//  CHECK (1 cycle):
//   - if n<2 or msg>=n -> ERR: done=1, err=1, result=0.
//   - else: R=1, B=msg, E=exp, bit counter=0.
//  MUL (exactly W cycles): two interleaved multipliers scan multiplier operand MSB-first.
//   Each cycle: acc = 2*acc + (bit ? mcand : 0), then subtract n while acc >= n (at most twice).
//   acc width W+2.
//   - mult A: R*B mod n.
//   - mult B: B*B mod n.
//  UPD (1 cycle): if E[0]: R <= accA; B <= accB; E <= E>>1; counter++.
//  Loop exit: counter==W (plus early-exit rule, see CONFIGURATION) -> FIN: done=1, err=0, result=R.
//  exp=0: result=1 (n>=2 guaranteed).
//  msg=0 and exp>0: result=0.
//  All intermediates strictly < n; no overflow for any W-bit n.
// CONFIGURATION
//  Macro: RSA_CONST_TIME_EN.
//  Defined:
//   - all W exponent bits processed; both multiplies run every bit.
//   - done exactly W*(W+1)+2 cycles after the accept edge, independent of exp/msg.
//   - error done 2 cycles after accept.
//  Undefined:
//   - UPD -> FIN as soon as shifted E==0.
//   - MUL skips mult A contribution when E[0]=0 (R unchanged).
//   - latency = (bitlen(exp))*(W+1)+2, with bitlen(0)=0 -> exp=0 completes in 2 cycles.
//  Functional results identical in both builds.
// TESTING (W=16 unless noted)
//  - Encrypt: n=3233, exp=17, msg=65 -> done once, result=2790, err=0; const build latency 274 cycles.
//  - Decrypt: n=3233, exp=2753, msg=2790 -> result=65; non-const latency 12*17+2=206 cycles.
//  - Error: n=3233, msg=4000 -> done at accept+2, err=1, result=0; n=1 -> err=1.
//  - Edges: exp=0, msg=5, n=7 -> result=1; msg=0, exp=3 -> 0; msg=n-1=3232, exp=2 -> 1.
//  - Handshake: start pulsed during busy ignored; inputs changed mid-job don't affect result;
//    back-to-back start on cycle after done accepted.
//  - Reset mid-MUL -> next cycle busy=0, done=0, result=0; fresh job gives correct result.
//  - W=64: random p,q primes, e=65537, d from key generator -> decrypt(encrypt(m)) == m.

Source files
------------

// File: rtl/rsa_modexp_engine.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_modexp_engine
//  Description : RSA modular exponentiation, result = msg^exp mod n.
//                Uses right-to-left square-and-multiply. Two bit-serial
//                interleaved modular multipliers run side by side: one
//                computes R*B mod n and the other computes B*B mod n.
//                Each exponent bit costs KEY_WIDTH multiply cycles plus
//                one update cycle.
//
//  Parameters  : KEY_WIDTH  width of n / exp / msg / result (>= 4)
//
//  Build option: RSA_CONST_TIME_EN
//                  defined   -> every exponent bit is processed, so the
//                               latency does not depend on the data.
//                  undefined -> the loop stops once the remaining exponent
//                               is zero, and the R*B contribution is
//                               skipped for zero exponent bits.
//
//  Ports       : clk     rising-edge clock
//                rst     synchronous active-high reset
//                start   job request, accepted only while idle
//                msg     message / ciphertext (must be < n)
//                exp     exponent (e or d)
//                n       modulus (must be >= 2)
//                busy    job in flight, up to and including the done cycle
//                done    one-cycle completion pulse
//                result  msg^exp mod n (0 on error), held until next accept
//                err     operand error (msg >= n or n < 2)
//
//  Revision    : 1.0  initial release
// ============================================================================
module rsa_modexp_engine #(
    parameter int KEY_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KEY_WIDTH-1:0] msg,
    input  logic [KEY_WIDTH-1:0] exp,
    input  logic [KEY_WIDTH-1:0] n,
    output logic                 busy,
    output logic                 done,
    output logic [KEY_WIDTH-1:0] result,
    output logic                 err
);

    localparam int c_ACC_W  = KEY_WIDTH + 2;
    localparam int c_MCNT_W = $clog2(KEY_WIDTH);
    localparam int c_BCNT_W = $clog2(KEY_WIDTH + 1);
    localparam logic [c_MCNT_W-1:0] c_MCNT_LAST = c_MCNT_W'(KEY_WIDTH - 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_LAST = c_BCNT_W'(KEY_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ERR   = 3'd2,
        S_MUL   = 3'd3,
        S_UPD   = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [KEY_WIDTH-1:0] r_n;       // latched modulus
    logic [KEY_WIDTH-1:0] r_r;       // running result R
    logic [KEY_WIDTH-1:0] r_b;       // running base B (holds msg until CHECK)
    logic [KEY_WIDTH-1:0] r_e;       // remaining exponent E
    logic [KEY_WIDTH-1:0] r_mbits;   // copy of B shifted out MSB-first
    logic [c_ACC_W-1:0]   r_acc_a;   // R*B accumulator
    logic [c_ACC_W-1:0]   r_acc_b;   // B*B accumulator
    logic [c_MCNT_W-1:0]  r_mcnt;    // multiply step counter
    logic [c_BCNT_W-1:0]  r_bcnt;    // exponent bit counter
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [KEY_WIDTH-1:0] r_result;

    logic                 w_accept;
    logic                 w_bad;
    logic                 w_bit_a;
    logic [c_ACC_W-1:0]   w_step_a;
    logic [c_ACC_W-1:0]   w_step_b;

    // One interleaved step: acc = 2*acc + (bit ? mcand : 0), reduced mod n.
    // The incoming acc is < n, so the sum is < 3n and two conditional
    // subtractions are enough to bring it back below n.
    function automatic logic [c_ACC_W-1:0] f_mul_step(
        input logic [c_ACC_W-1:0]   acc,
        input logic                 mbit,
        input logic [KEY_WIDTH-1:0] mcand,
        input logic [KEY_WIDTH-1:0] modulus
    );
        logic [c_ACC_W-1:0] t;
        logic [c_ACC_W-1:0] m;
        m = {2'b00, modulus};
        t = acc + acc + (mbit ? {2'b00, mcand} : '0);
        if (t >= m) t = t - m;
        if (t >= m) t = t - m;
        return t;
    endfunction

    assign w_accept = (r_state == S_IDLE) && start && !r_busy;
    assign w_bad    = (r_n < KEY_WIDTH'(2)) || (r_b >= r_n);

`ifdef RSA_CONST_TIME_EN
    assign w_bit_a = r_mbits[KEY_WIDTH-1];
`else
    // R is left unchanged when E[0]=0, so the R*B product is not needed.
    assign w_bit_a = r_mbits[KEY_WIDTH-1] & r_e[0];
`endif

    assign w_step_a = f_mul_step(r_acc_a, w_bit_a, r_r, r_n);
    assign w_step_b = f_mul_step(r_acc_b, r_mbits[KEY_WIDTH-1], r_b, r_n);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CHECK;
            S_CHECK: begin
                if (w_bad) begin
                    w_next = S_ERR;
                end else begin
`ifdef RSA_CONST_TIME_EN
                    w_next = S_MUL;
`else
                    w_next = (r_e == '0) ? S_FIN : S_MUL;
`endif
                end
            end
            S_MUL:   if (r_mcnt == c_MCNT_LAST) w_next = S_UPD;
            S_UPD: begin
`ifdef RSA_CONST_TIME_EN
                w_next = (r_bcnt == c_BCNT_LAST) ? S_FIN : S_MUL;
`else
                w_next = ((r_e >> 1) == '0 || r_bcnt == c_BCNT_LAST) ? S_FIN : S_MUL;
`endif
            end
            S_ERR:   w_next = S_IDLE;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and handshake registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n      <= '0;
            r_r      <= '0;
            r_b      <= '0;
            r_e      <= '0;
            r_mbits  <= '0;
            r_acc_a  <= '0;
            r_acc_b  <= '0;
            r_mcnt   <= '0;
            r_bcnt   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            // busy covers the done cycle, which also keeps a start request
            // in that cycle from being taken.
            if (w_accept)    r_busy <= 1'b1;
            else if (r_done) r_busy <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_n      <= n;
                        r_b      <= msg;
                        r_e      <= exp;
                        r_err    <= 1'b0;
                        r_result <= '0;
                    end
                end
                S_CHECK: begin
                    r_r     <= KEY_WIDTH'(1);
                    r_mbits <= r_b;
                    r_acc_a <= '0;
                    r_acc_b <= '0;
                    r_mcnt  <= '0;
                    r_bcnt  <= '0;
                end
                S_MUL: begin
                    r_acc_a <= w_step_a;
                    r_acc_b <= w_step_b;
                    r_mbits <= r_mbits << 1;
                    r_mcnt  <= r_mcnt + c_MCNT_W'(1);
                end
                S_UPD: begin
                    if (r_e[0]) r_r <= r_acc_a[KEY_WIDTH-1:0];
                    r_b     <= r_acc_b[KEY_WIDTH-1:0];
                    r_mbits <= r_acc_b[KEY_WIDTH-1:0];
                    r_e     <= r_e >> 1;
                    r_bcnt  <= r_bcnt + c_BCNT_W'(1);
                    r_acc_a <= '0;
                    r_acc_b <= '0;
                    r_mcnt  <= '0;
                end
                S_ERR: begin
                    r_done   <= 1'b1;
                    r_err    <= 1'b1;
                    r_result <= '0;
                end
                S_FIN: begin
                    r_done   <= 1'b1;
                    r_err    <= 1'b0;
                    r_result <= r_r;
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rsa_modexp_engine
//  Description : Directed testbench for rsa_modexp_engine. It has a 16-bit
//                instance for functional, edge-case and handshake steps, and
//                a 64-bit instance for an encrypt/decrypt round trip.
//                Expected values are queued when a job is accepted and
//                compared when done is seen.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rsa_modexp_engine;

    localparam int W  = 16;
    localparam int WL = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_start, s_busy, s_done, s_err;
    logic [W-1:0]  s_msg, s_exp, s_n, s_result;
    logic          l_start, l_busy, l_done, l_err;
    logic [WL-1:0] l_msg, l_exp, l_n, l_result;

    always #5 clk = ~clk;

    rsa_modexp_engine #(.KEY_WIDTH(W)) u_dut16 (
        .clk(clk), .rst(rst), .start(s_start), .msg(s_msg), .exp(s_exp), .n(s_n),
        .busy(s_busy), .done(s_done), .result(s_result), .err(s_err)
    );

    rsa_modexp_engine #(.KEY_WIDTH(WL)) u_dut64 (
        .clk(clk), .rst(rst), .start(l_start), .msg(l_msg), .exp(l_exp), .n(l_n),
        .busy(l_busy), .done(l_done), .result(l_result), .err(l_err)
    );

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] modpow(input logic [63:0] m, input logic [63:0] e,
                                           input logic [63:0] nn);
        logic [127:0] r;
        logic [127:0] b;
        r = 128'd1;
        b = {64'd0, m};
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * b) % {64'd0, nn};
            b = (b * b) % {64'd0, nn};
        end
        return r[63:0];
    endfunction

    function automatic int bitlen(input logic [63:0] e);
        for (int i = 63; i >= 0; i--) if (e[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [63:0] modinv(input logic [63:0] a, input logic [63:0] m);
        logic signed [129:0] t, nt, r, nr, q, tmp;
        t  = 0;
        nt = 1;
        r  = $signed({66'd0, m});
        nr = $signed({66'd0, a});
        while (nr != 0) begin
            q   = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        if (t < 0) t = t + $signed({66'd0, m});
        return t[63:0];
    endfunction

    // Runs one job on the 16-bit (wide=0) or 64-bit (wide=1) instance.
    // With poke set, the inputs are scrambled right after the accept edge
    // and a stray start pulse is sent mid-job. Neither may affect the job.
    task automatic run_job(input bit wide, input logic [63:0] m, input logic [63:0] e,
                           input logic [63:0] nn, input bit poke, output logic [63:0] got);
        exp_t x, y;
        int   cyc, wb;
        bit   seen;
        wb    = wide ? WL : W;
        x.err = (nn < 64'd2) || (m >= nn);
        x.res = x.err ? 64'd0 : modpow(m, e, nn);
`ifdef RSA_CONST_TIME_EN
        x.lat = x.err ? 2 : wb * (wb + 1) + 2;
`else
        x.lat = x.err ? 2 : bitlen(e) * (wb + 1) + 2;
`endif
        if (wide) begin
            l_msg = m; l_exp = e; l_n = nn; l_start = 1'b1;
        end else begin
            s_msg = m[W-1:0]; s_exp = e[W-1:0]; s_n = nn[W-1:0]; s_start = 1'b1;
        end
        @(posedge clk);
        sb.push_back(x);
        #1;
        s_start = 1'b0;
        l_start = 1'b0;
        chk("busy_after_accept", wide ? {63'd0, l_busy} : {63'd0, s_busy}, 64'd1);
        if (poke) begin
            if (wide) begin
                l_msg = {$urandom, $urandom}; l_exp = {$urandom, $urandom}; l_n = {$urandom, $urandom};
            end else begin
                s_msg = W'($urandom); s_exp = W'($urandom); s_n = W'($urandom);
            end
        end
        seen = 1'b0;
        cyc  = 0;
        got  = '0;
        while (!seen && cyc < x.lat + 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (wide ? l_done : s_done) seen = 1'b1;
            if (wide) l_start = (poke && cyc == 3 && x.lat > 8);
            else      s_start = (poke && cyc == 3 && x.lat > 8);
        end
        s_start = 1'b0;
        l_start = 1'b0;
        if (seen && sb.size() > 0) begin
            y   = sb.pop_front();
            got = wide ? l_result : {48'd0, s_result};
            chk("latency", 64'(cyc), 64'(y.lat));
            chk("result", got, y.res);
            chk("err", wide ? {63'd0, l_err} : {63'd0, s_err}, {63'd0, y.err});
        end else begin
            chk("done_timeout", 64'd0, 64'd1);
            sb.delete();
        end
        // The cycle after done: the pulse has ended and the engine is free.
        @(posedge clk);
        #1;
        chk("done_pulse", wide ? {63'd0, l_done} : {63'd0, s_done}, 64'd0);
        chk("busy_release", wide ? {63'd0, l_busy} : {63'd0, s_busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] got, p, q, nn, phi, d, ct, pt, m64;
        int          rn, rm, re;

        rst = 1'b1;
        s_start = 1'b0; s_msg = '0; s_exp = '0; s_n = '0;
        l_start = 1'b0; l_msg = '0; l_exp = '0; l_n = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, s_busy}, 64'd0);
        chk("rst_done", {63'd0, s_done}, 64'd0);
        chk("rst_err", {63'd0, s_err}, 64'd0);
        chk("rst_result", {48'd0, s_result}, 64'd0);
        chk("rst_busy64", {63'd0, l_busy}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_job(1'b0, 64'd65, 64'd17, 64'd3233, 1'b0, got);
        chk("encrypt_3233", got, 64'd2790);
        run_job(1'b0, 64'd2790, 64'd2753, 64'd3233, 1'b1, got);
        chk("decrypt_3233", got, 64'd65);
        run_job(1'b0, 64'd4000, 64'd17, 64'd3233, 1'b0, got);
        run_job(1'b0, 64'd0, 64'd17, 64'd1, 1'b0, got);
        run_job(1'b0, 64'd5, 64'd0, 64'd7, 1'b0, got);
        chk("exp_zero", got, 64'd1);
        run_job(1'b0, 64'd0, 64'd3, 64'd3233, 1'b0, got);
        chk("msg_zero", got, 64'd0);
        run_job(1'b0, 64'd3232, 64'd2, 64'd3233, 1'b0, got);
        chk("msg_nm1", got, 64'd1);

        // Reset in the middle of the multiply phase.
        s_msg = 16'd65; s_exp = 16'd17; s_n = 16'd3233; s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", {63'd0, s_busy}, 64'd0);
        chk("midrst_done", {63'd0, s_done}, 64'd0);
        chk("midrst_result", {48'd0, s_result}, 64'd0);
        chk("midrst_err", {63'd0, s_err}, 64'd0);
        run_job(1'b0, 64'd65, 64'd17, 64'd3233, 1'b0, got);
        chk("after_rst", got, 64'd2790);

        for (int i = 0; i < 4; i++) begin
            rn = $urandom_range(65535, 2);
            rm = $urandom_range(rn - 1, 0);
            re = $urandom_range(65535, 1);
            run_job(1'b0, 64'(rm), 64'(re), 64'(rn), 1'b1, got);
        end

        // 64-bit round trip with e = 65537.
        p   = 64'd4294967291;
        q   = 64'd4294967279;
        nn  = p * q;
        phi = (p - 64'd1) * (q - 64'd1);
        d   = modinv(64'd65537, phi);
        m64 = 64'h0123456789ABCDEF;
        run_job(1'b1, m64, 64'd65537, nn, 1'b0, ct);
        run_job(1'b1, ct, d, nn, 1'b1, pt);
        chk("roundtrip64", pt, m64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
